// File: rtl/fir_interp_coef_reloader.sv
// Run-time coefficient reload controller for the FIR interpolator:
// stall, drain, stream coefficients into RAM, flush delay line, release.
`timescale 1ns/1ps
module fir_interp_coef_reloader #(
    parameter int FILTER_ORDER  = 256,
    parameter int INTERPOLATION = 32,
    parameter int DATA_WIDTH    = 16,
    parameter int COEF_WIDTH    = 16,
    parameter int DRAIN_CYCLES  = 64,
    parameter int TIMEOUT       = 1024,
    parameter int COEF_AWIDTH   = $clog2(FILTER_ORDER)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reload_req_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   data_val_i,
    output logic                   data_rdy_o,
    input  logic [COEF_WIDTH-1:0]  coef_i,
    input  logic                   coef_val_i,
    output logic                   coef_rdy_o,
    output logic [DATA_WIDTH-1:0]  fir_data_o,
    output logic                   fir_data_val_o,
    output logic                   fir_coef_we_o,
    output logic [COEF_AWIDTH-1:0] fir_coef_addr_o,
    output logic [COEF_WIDTH-1:0]  fir_coef_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int NZ = FILTER_ORDER / INTERPOLATION;
    localparam int DW = $clog2(DRAIN_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int BW = $clog2(FILTER_ORDER) + 1;
    localparam int PW = $clog2(INTERPOLATION) + 1;
    localparam int ZW = $clog2(NZ) + 1;

    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(FILTER_ORDER - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(INTERPOLATION - 1);
    localparam logic [ZW-1:0] ZERO_LAST  = ZW'(NZ - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic [TW-1:0]          idle_q, idle_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [ZW-1:0]          zcnt_q, zcnt_d;
    logic [DATA_WIDTH-1:0]  fdata_q, fdata_d;
    logic                   fval_q, fval_d;
    logic                   we_q, we_d;
    logic [COEF_AWIDTH-1:0] addr_q, addr_d;
    logic [COEF_WIDTH-1:0]  cdata_q, cdata_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   beat;

    assign beat = (state_q == LOAD) && coef_val_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            drain_q <= '0;
            idle_q  <= '0;
            beat_q  <= '0;
            phase_q <= '0;
            zcnt_q  <= '0;
            fdata_q <= '0;
            fval_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            idle_q  <= idle_d;
            beat_q  <= beat_d;
            phase_q <= phase_d;
            zcnt_q  <= zcnt_d;
            fdata_q <= fdata_d;
            fval_q  <= fval_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cdata_q <= cdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        idle_d  = idle_q;
        beat_d  = beat_q;
        phase_d = phase_q;
        zcnt_d  = zcnt_q;
        fdata_d = fdata_q;
        fval_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        cdata_d = cdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (data_val_i) begin
                    fdata_d = data_i;
                    fval_d  = 1'b1;
                end
                if (reload_req_i) begin
                    state_d = DRAIN;
                    drain_d = '0;
                    err_d   = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = LOAD;
                    idle_d  = '0;
                    beat_d  = '0;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            LOAD: begin
                if (beat) begin
                    we_d    = 1'b1;
                    addr_d  = beat_q[COEF_AWIDTH-1:0];
                    cdata_d = coef_i;
                    idle_d  = '0;
                    // first flush zero leaves together with the last write
                    if (beat_q == BEAT_LAST) begin
                        state_d = FLUSH;
                        phase_d = '0;
                        zcnt_d  = '0;
                        fdata_d = '0;
                        fval_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            FLUSH: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (zcnt_q == ZERO_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        zcnt_d  = zcnt_q + ZW'(1);
                        fdata_d = '0;
                        fval_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_rdy_o      = (state_q == IDLE);
    assign coef_rdy_o      = (state_q == LOAD);
    assign busy_o          = (state_q != IDLE);
    assign fir_data_o      = fdata_q;
    assign fir_data_val_o  = fval_q;
    assign fir_coef_we_o   = we_q;
    assign fir_coef_addr_o = addr_q;
    assign fir_coef_data_o = cdata_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_fir_interp_coef_reloader.sv
// Bench for fir_interp_coef_reloader: directed/randomized reloads and
// pass-through, checked against event timelines computed from the rules.
`timescale 1ns/1ps
module tb_fir_interp_coef_reloader;

    localparam int FO = 8;
    localparam int IP = 2;
    localparam int DC = 4;
    localparam int TO = 16;
    localparam int NZ = FO / IP;
    localparam int AW = $clog2(FO);

    typedef struct {
        int c;
        int a;
        int d;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_i, reload_req_i, data_val_i, coef_val_i;
    logic [15:0]   data_i, coef_i;
    logic          data_rdy_o, coef_rdy_o, fir_data_val_o, fir_coef_we_o;
    logic [15:0]   fir_data_o, fir_coef_data_o;
    logic [AW-1:0] fir_coef_addr_o;
    logic          busy_o, done_o, err_o;

    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    ev_t  wq[$], dq[$], expw[$], expd[$];
    int   doneq[$];

    fir_interp_coef_reloader #(
        .FILTER_ORDER(FO), .INTERPOLATION(IP), .DATA_WIDTH(16),
        .COEF_WIDTH(16), .DRAIN_CYCLES(DC), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .reload_req_i(reload_req_i),
        .data_i(data_i), .data_val_i(data_val_i), .data_rdy_o(data_rdy_o),
        .coef_i(coef_i), .coef_val_i(coef_val_i), .coef_rdy_o(coef_rdy_o),
        .fir_data_o(fir_data_o), .fir_data_val_o(fir_data_val_o),
        .fir_coef_we_o(fir_coef_we_o), .fir_coef_addr_o(fir_coef_addr_o),
        .fir_coef_data_o(fir_coef_data_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int a, input int d);
        ev_t e;
        e.c = c;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    // observed event log, sampled mid-cycle
    always @(negedge clk) begin
        if (fir_coef_we_o)
            wq.push_back(mk(cyc, int'(fir_coef_addr_o), int'(fir_coef_data_o)));
        if (fir_data_val_o)
            dq.push_back(mk(cyc, 0, int'($signed(fir_data_o))));
        if (done_o)
            doneq.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fd"}, fir_data_o, 0);
        chk({tag, "_fv"}, fir_data_val_o, 0);
        chk({tag, "_we"}, fir_coef_we_o, 0);
        chk({tag, "_ad"}, fir_coef_addr_o, 0);
        chk({tag, "_cd"}, fir_coef_data_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_crdy"}, coef_rdy_o, 0);
        chk({tag, "_drdy"}, data_rdy_o, 1);
    endtask

    task automatic clear_logs();
        wq.delete();
        dq.delete();
        expw.delete();
        expd.delete();
        doneq.delete();
    endtask

    task automatic cmp_logs(input string tag, input int exp_done);
        chk({tag, "_wn"}, wq.size(), expw.size());
        for (int k = 0; k < expw.size() && k < wq.size(); k++) begin
            chk({tag, "_wcyc"}, wq[k].c, expw[k].c);
            chk({tag, "_wadr"}, wq[k].a, expw[k].a);
            chk({tag, "_wdat"}, wq[k].d, expw[k].d);
        end
        chk({tag, "_dn"}, dq.size(), expd.size());
        for (int k = 0; k < expd.size() && k < dq.size(); k++) begin
            chk({tag, "_dcyc"}, dq[k].c, expd[k].c);
            chk({tag, "_ddat"}, dq[k].d, expd[k].d);
        end
        chk({tag, "_donen"}, doneq.size(), (exp_done >= 0) ? 1 : 0);
        if (exp_done >= 0 && doneq.size() > 0)
            chk({tag, "_donecyc"}, doneq[0], exp_done);
    endtask

    task automatic passthru(input int n, input bit rnd);
        int pv[3] = '{5, -3, 7};
        int d;
        bit v;
        clear_logs();
        for (int k = 0; k < n; k++) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = rnd ? ($urandom_range(0, 65535) - 32768) : pv[k % 3];
            chk("pt_drdy", data_rdy_o, 1);
            chk("pt_busy", busy_o, 0);
            data_val_i = v;
            data_i = 16'(d);
            if (v) expd.push_back(mk(cyc + 1, 0, d));
            tick();
        end
        data_val_i = 1'b0;
        tick();
        tick();
        cmp_logs(rnd ? "ptr" : "ptd", -1);
    endtask

    // mode: 0 back-to-back, 1 every 3rd cycle, 2 random gaps
    task automatic reload(input int mode, input int nbeats, input bit rst_abort,
                          input bit with_data, input bit req_in_load);
        logic [15:0] c[FO];
        int t, ls, u, i, gap, done_at;
        bit v;
        clear_logs();
        for (int k = 0; k < FO; k++) c[k] = 16'($urandom);
        done_at = -1;
        t = cyc;
        reload_req_i = 1'b1;
        if (with_data) begin
            data_i = 16'(9);
            data_val_i = 1'b1;
            expd.push_back(mk(t + 1, 0, 9));
        end
        chk("req_drdy", data_rdy_o, 1);
        tick();
        reload_req_i = 1'b0;
        chk("t1_busy", busy_o, 1);
        chk("t1_drdy", data_rdy_o, 0);
        chk("t1_err", err_o, 0);
        if (with_data) data_i = 16'(11);
        ls = t + DC + 1;
        u = ls - 1;
        i = 0;
        gap = 0;
        while (cyc < ls) begin
            chk("drain_crdy", coef_rdy_o, 0);
            chk("drain_busy", busy_o, 1);
            coef_val_i = 1'b1;
            coef_i = c[0];
            tick();
        end
        data_val_i = 1'b0;
        while (i < nbeats) begin
            chk("load_crdy", coef_rdy_o, 1);
            case (mode)
                0: v = 1'b1;
                1: v = ((cyc - ls) % 3) == 0;
                default: v = ($urandom_range(0, 2) != 0) || (gap >= 4);
            endcase
            gap = v ? 0 : gap + 1;
            reload_req_i = req_in_load && (cyc == ls + 1);
            coef_val_i = v;
            coef_i = v ? c[i] : 16'($urandom);
            if (v) begin
                expw.push_back(mk(cyc + 1, i, int'(c[i])));
                u = cyc;
                i++;
            end
            tick();
        end
        coef_val_i = 1'b0;
        reload_req_i = 1'b0;
        if (rst_abort) begin
            rst_i = 1'b1;
            coef_val_i = 1'b1;
            coef_i = c[i];
            tick();
            rst_i = 1'b0;
            coef_val_i = 1'b0;
            chk_reset("abort");
            repeat (DC + TO + 4) begin
                chk("abort_idle", busy_o, 0);
                tick();
            end
        end else if (i == FO) begin
            for (int k = 0; k < NZ; k++) expd.push_back(mk(u + 1 + k * IP, 0, 0));
            done_at = u + 1 + NZ * IP;
            while (cyc < done_at) begin
                chk("flush_busy", busy_o, 1);
                chk("flush_drdy", data_rdy_o, 0);
                tick();
            end
            chk("end_busy", busy_o, 0);
            chk("end_drdy", data_rdy_o, 1);
            chk("end_done", done_o, 1);
            chk("end_err", err_o, 0);
            repeat (4) begin
                tick();
                chk("post_busy", busy_o, 0);
            end
        end else begin
            while (cyc <= u + TO) begin
                chk("to_busy", busy_o, 1);
                tick();
            end
            chk("to_idle", busy_o, 0);
            chk("to_err", err_o, 1);
            chk("to_done", done_o, 0);
            tick();
            tick();
            chk("to_err_sticky", err_o, 1);
        end
        cmp_logs("rl", done_at);
    endtask

    initial begin
        rst_i = 1'b1;
        reload_req_i = 1'b0;
        data_val_i = 1'b0;
        coef_val_i = 1'b0;
        data_i = '0;
        coef_i = '0;
        tick();
        tick();
        tick();
        chk_reset("reset");
        rst_i = 1'b0;
        tick();
        passthru(3, 1'b0);
        passthru(30, 1'b1);
        reload(0, FO, 1'b0, 1'b0, 1'b0);
        reload(1, FO, 1'b0, 1'b0, 1'b0);
        reload(0, 3, 1'b0, 1'b0, 1'b0);
        reload(2, FO, 1'b0, 1'b0, 1'b0);
        reload(0, FO, 1'b0, 1'b1, 1'b1);
        reload(0, 4, 1'b1, 1'b0, 1'b0);
        reload(0, FO, 1'b0, 1'b0, 1'b0);
        reload(2, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            passthru(10, 1'b1);
            reload(2, FO, 1'b0, 1'b1, 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
